uart_tx_cfg: RTL and testbench

- Runtime-configurable UART transmitter; the next-generation serial TX for board-level links, e.g. host console and 7-segment debug echo.
- Frame format is selectable per frame: baud divisor, 5–8 data bits, none/even/odd parity, 1 or 2 stop bits.
- Valid/ready byte handshake toward the upstream producer.
- Single serial output line; LSB-first, standard start/stop framing.

---
 rtl/uart_tx_cfg_pkg.sv | 24 ++
 rtl/uart_tx_cfg_if.sv | 26 ++
 rtl/uart_baud_cnt.sv | 26 ++
 rtl/uart_tx_cfg.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_cfg_pkg.sv
// rtl/uart_tx_cfg_pkg.sv - shared types and frame-format decode helpers for the configurable UART
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  typedef enum logic [1:0] {NONE = 2'b00, EVEN = 2'b01, ODD = 2'b10} parity_t;

  localparam int MIN_DIV = 2;

  function automatic logic [3:0] data_bits(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

  // Code 2'b11 is a second spelling of "no parity".
  function automatic parity_t parity_decode(input logic [1:0] code);
    parity_t p;
    case (code)
      2'b01:   p = EVEN;
      2'b10:   p = ODD;
      default: p = NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// rtl/uart_tx_cfg_if.sv - byte handshake, frame config and serial outputs of the configurable TX
interface uart_tx_cfg_if #(parameter int DIV_W = 16);

  logic             i_TX_DV;
  logic [7:0]       i_TX_Byte;
  logic             o_TX_Ready;
  logic             i_Div_Override;
  logic [DIV_W-1:0] i_Clks_Per_Bit;
  logic [1:0]       i_Data_Bits;
  logic [1:0]       i_Parity;
  logic             i_Two_Stop;
  logic             o_TX_Serial;
  logic             o_TX_Active;
  logic             o_TX_Done;

  modport master (
    output i_TX_DV, i_TX_Byte, i_Div_Override, i_Clks_Per_Bit, i_Data_Bits, i_Parity, i_Two_Stop,
    input  o_TX_Ready, o_TX_Serial, o_TX_Active, o_TX_Done
  );

  modport slave (
    input  i_TX_DV, i_TX_Byte, i_Div_Override, i_Clks_Per_Bit, i_Data_Bits, i_Parity, i_Two_Stop,
    output o_TX_Ready, o_TX_Serial, o_TX_Active, o_TX_Done
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - loadable bit-period counter; bit_end marks the last clock of each bit
module uart_baud_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign bit_end = !load && (cnt_q == div - DIV_W'(1));

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (load || bit_end) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - runtime-configurable UART transmitter, per-frame format latched on accept
// Optional UART_TX_HOLD_EN adds a one-entry holding register for back-to-back frames.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 217
) (
  input logic           i_Clock,
  input logic           i_Rst,
  uart_tx_cfg_if.slave  bus
);

  tx_state_t        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_acc_q, par_acc_d;
  logic [2:0]       idx_q, idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       nbits_q, nbits_d;
  parity_t          par_q, par_d;
  logic             two_stop_q, two_stop_d;
  logic             serial_q, serial_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  logic [DIV_W-1:0] div_in, div_clamped;
  logic             baud_load, bit_end, frame_end, accept, ready;
  logic             launch, launch_from_hold;

`ifdef UART_TX_HOLD_EN
  logic             hold_full_q, hold_full_d;
  logic [7:0]       hold_byte_q, hold_byte_d;
  logic [DIV_W-1:0] hold_div_q, hold_div_d;
  logic [3:0]       hold_nbits_q, hold_nbits_d;
  parity_t          hold_par_q, hold_par_d;
  logic             hold_two_q, hold_two_d;

  // The slot being drained on this edge may be refilled on the same edge.
  assign ready = ~hold_full_q | frame_end;
`else
  logic             ready_q, ready_d;

  assign ready = ready_q;
`endif

  assign accept    = bus.i_TX_DV && ready;
  assign frame_end = (state_q == STOP) && bit_end && !(two_stop_q && idx_q == 3'd0);

  always_comb begin
    div_in      = bus.i_Div_Override ? bus.i_Clks_Per_Bit : DIV_W'(DEFAULT_DIV);
    div_clamped = (div_in < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_in;
  end

  uart_baud_cnt #(.DIV_W(DIV_W)) u_baud (
    .clk     (i_Clock),
    .rst     (i_Rst),
    .load    (baud_load),
    .div     (div_q),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d          = state_q;
    shift_d          = shift_q;
    par_acc_d        = par_acc_q;
    idx_d            = idx_q;
    div_d            = div_q;
    nbits_d          = nbits_q;
    par_d            = par_q;
    two_stop_d       = two_stop_q;
    serial_d         = serial_q;
    active_d         = active_q;
    done_d           = 1'b0;
    baud_load        = 1'b0;
    launch           = 1'b0;
    launch_from_hold = 1'b0;
`ifdef UART_TX_HOLD_EN
    hold_full_d      = hold_full_q;
    hold_byte_d      = hold_byte_q;
    hold_div_d       = hold_div_q;
    hold_nbits_d     = hold_nbits_q;
    hold_par_d       = hold_par_q;
    hold_two_d       = hold_two_q;
`else
    ready_d          = ready_q;
`endif

    case (state_q)
      IDLE: begin
        baud_load = 1'b1;
        if (accept) launch = 1'b1;
      end
      START: begin
        // Line still high here means this is the accept-to-line latency cycle.
        if (serial_q) begin
          serial_d  = 1'b0;
          baud_load = 1'b1;
        end else if (bit_end) begin
          state_d   = DATA;
          serial_d  = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          par_acc_d = par_acc_q ^ shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if ({1'b0, idx_q} == nbits_q - 4'd1) begin
            if (par_q == NONE) begin
              state_d  = STOP;
              serial_d = 1'b1;
              idx_d    = 3'd0;
            end else begin
              state_d  = PARITY;
              serial_d = par_acc_q ^ (par_q == ODD);
            end
          end else begin
            idx_d     = idx_q + 3'd1;
            serial_d  = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            par_acc_d = par_acc_q ^ shift_q[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d  = STOP;
          serial_d = 1'b1;
          idx_d    = 3'd0;
        end
      end
      STOP: begin
        if (bit_end && !frame_end) idx_d = 3'd1;
        if (frame_end) begin
          done_d   = 1'b1;
          state_d  = IDLE;
          active_d = 1'b0;
`ifdef UART_TX_HOLD_EN
          if (hold_full_q) begin
            launch           = 1'b1;
            launch_from_hold = 1'b1;
          end else if (accept) begin
            launch = 1'b1;
          end
`else
          ready_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d   = START;
      active_d  = 1'b1;
      par_acc_d = 1'b0;
      idx_d     = 3'd0;
      // Back-to-back frames skip the latency cycle so no idle clock appears.
      if (state_q != IDLE) serial_d = 1'b0;
`ifdef UART_TX_HOLD_EN
      if (launch_from_hold) begin
        shift_d     = hold_byte_q;
        div_d       = hold_div_q;
        nbits_d     = hold_nbits_q;
        par_d       = hold_par_q;
        two_stop_d  = hold_two_q;
        hold_full_d = 1'b0;
      end else begin
        shift_d    = bus.i_TX_Byte;
        div_d      = div_clamped;
        nbits_d    = data_bits(bus.i_Data_Bits);
        par_d      = parity_decode(bus.i_Parity);
        two_stop_d = bus.i_Two_Stop;
      end
`else
      shift_d    = bus.i_TX_Byte;
      div_d      = div_clamped;
      nbits_d    = data_bits(bus.i_Data_Bits);
      par_d      = parity_decode(bus.i_Parity);
      two_stop_d = bus.i_Two_Stop;
      ready_d    = 1'b0;
`endif
    end

`ifdef UART_TX_HOLD_EN
    if (accept && !(launch && !launch_from_hold)) begin
      hold_full_d  = 1'b1;
      hold_byte_d  = bus.i_TX_Byte;
      hold_div_d   = div_clamped;
      hold_nbits_d = data_bits(bus.i_Data_Bits);
      hold_par_d   = parity_decode(bus.i_Parity);
      hold_two_d   = bus.i_Two_Stop;
    end
`endif
  end

  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      par_acc_q    <= 1'b0;
      idx_q        <= '0;
      div_q        <= '0;
      nbits_q      <= '0;
      par_q        <= NONE;
      two_stop_q   <= 1'b0;
      serial_q     <= 1'b1;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
`ifdef UART_TX_HOLD_EN
      hold_full_q  <= 1'b0;
      hold_byte_q  <= '0;
      hold_div_q   <= '0;
      hold_nbits_q <= '0;
      hold_par_q   <= NONE;
      hold_two_q   <= 1'b0;
`else
      ready_q      <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      par_acc_q    <= par_acc_d;
      idx_q        <= idx_d;
      div_q        <= div_d;
      nbits_q      <= nbits_d;
      par_q        <= par_d;
      two_stop_q   <= two_stop_d;
      serial_q     <= serial_d;
      active_q     <= active_d;
      done_q       <= done_d;
`ifdef UART_TX_HOLD_EN
      hold_full_q  <= hold_full_d;
      hold_byte_q  <= hold_byte_d;
      hold_div_q   <= hold_div_d;
      hold_nbits_q <= hold_nbits_d;
      hold_par_q   <= hold_par_d;
      hold_two_q   <= hold_two_d;
`else
      ready_q      <= ready_d;
`endif
    end
  end

  assign bus.o_TX_Ready  = ready;
  assign bus.o_TX_Serial = serial_q;
  assign bus.o_TX_Active = active_q;
  assign bus.o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - randomized and directed frames checked against a per-sample line model
module tb_uart_tx_cfg;

`ifdef UART_TX_HOLD_EN
  localparam bit HOLD_BUILD = 1'b1;
`else
  localparam bit HOLD_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DIV_W(16)) bus ();

  uart_tx_cfg #(.DIV_W(16), .DEFAULT_DIV(217)) dut (
    .i_Clock (clk),
    .i_Rst   (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;
  logic [2:0] exp_q[$];  // {serial, active, done} per negedge sample

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int eff_n(input bit ovr, input int cpb);
    if (!ovr) return 217;
    return (cpb < 2) ? 2 : cpb;
  endfunction

  // Model: frame = start, D data bits LSB first, optional parity, 1 or 2 stops; each bit N samples.
  function automatic void add_frame(input logic [7:0] b, input int code_bits, input int code_par,
                                    input bit two, input int n);
    bit bits[$];
    bit p = 1'b0;
    int nb = 5 + code_bits;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(b[i]);
      p ^= b[i];
    end
    if (code_par == 1) bits.push_back(p);
    if (code_par == 2) bits.push_back(!p);
    bits.push_back(1'b1);
    if (two) bits.push_back(1'b1);
    foreach (bits[i])
      for (int j = 0; j < n; j++) exp_q.push_back({bits[i], 1'b1, 1'b0});
  endfunction

  task automatic apply_cfg(input logic [7:0] b, input bit ovr, input int cpb, input int code_bits,
                           input int code_par, input bit two);
    bus.i_TX_Byte      = b;
    bus.i_Div_Override = ovr;
    bus.i_Clks_Per_Bit = 16'(cpb);
    bus.i_Data_Bits    = 2'(code_bits);
    bus.i_Parity       = 2'(code_par);
    bus.i_Two_Stop     = two;
  endtask

  task automatic send(input logic [7:0] b, input bit ovr, input int cpb, input int code_bits,
                      input int code_par, input bit two);
    int w = 0;
    apply_cfg(b, ovr, cpb, code_bits, code_par, two);
    while (bus.o_TX_Ready !== 1'b1 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) check("ready_wait", 32'(bus.o_TX_Ready), 32'd1);
    bus.i_TX_DV = 1'b1;
    @(posedge clk);
    #1;
    bus.i_TX_DV = 1'b0;
    // Config changes after accept must not affect the frame in flight.
    apply_cfg(8'($urandom), 1'($urandom), $urandom_range(0, 9), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'($urandom));
  endtask

  task automatic run_samples(input string tag);
    logic [2:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      check(tag, {29'd0, bus.o_TX_Serial, bus.o_TX_Active, bus.o_TX_Done}, {29'd0, e});
    end
  endtask

  task automatic frame(input logic [7:0] b, input bit ovr, input int cpb, input int code_bits,
                       input int code_par, input bit two, input string tag);
    send(b, ovr, cpb, code_bits, code_par, two);
    exp_q.delete();
    exp_q.push_back(3'b110);
    add_frame(b, code_bits, code_par, two, eff_n(ovr, cpb));
    exp_q.push_back(3'b101);
    exp_q.push_back(3'b100);
    run_samples(tag);
    check({tag, "_ready"}, 32'(bus.o_TX_Ready), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0] e;
    int dc, lows, mark;
    rst = 1'b1;
    bus.i_TX_DV = 1'b0;
    apply_cfg(8'h00, 1'b1, 4, 3, 0, 1'b0);
    #2;
    check("rst_serial", 32'(bus.o_TX_Serial), 32'd1);
    check("rst_active", 32'(bus.o_TX_Active), 32'd0);
    check("rst_done",   32'(bus.o_TX_Done),   32'd0);
    check("rst_ready",  32'(bus.o_TX_Ready),  32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    frame(8'hA5, 1'b1, 4, 3, 0, 1'b0, "a5_8n1");
    frame(8'h55, 1'b1, 4, 2, 1, 1'b0, "55_7e1");
    frame(8'h55, 1'b1, 4, 2, 2, 1'b0, "55_7o1");
    frame(8'h1F, 1'b1, 3, 0, 0, 1'b1, "1f_5n2");
    frame(8'hFF, 1'b1, 3, 0, 0, 1'b1, "ff_5n2_hi_ignored");
    frame(8'h3C, 1'b1, 0, 3, 0, 1'b0, "div0_clamp");
    frame(8'hC3, 1'b1, 1, 3, 1, 1'b0, "div1_clamp");
    frame(8'h0F, 1'b1, 3, 3, 3, 1'b0, "par11_none");
    frame(8'h96, 1'b0, 5, 0, 0, 1'b0, "default_div");
    frame(8'h80, 1'b1, 16'hFFFF - 16'hFFFD, 3, 2, 1'b1, "8o2_n2");

    for (int i = 0; i < 12; i++)
      frame(8'($urandom), 1'b1, $urandom_range(0, 6), $urandom_range(0, 3),
            $urandom_range(0, 3), 1'($urandom), "random");

    // Reset in the middle of a frame.
    send(8'hA5, 1'b1, 4, 3, 0, 1'b0);
    exp_q.delete();
    exp_q.push_back(3'b110);
    add_frame(8'hA5, 3, 0, 1'b0, 4);
    for (int i = 0; i < 11; i++) begin
      e = exp_q.pop_front();
      @(negedge clk);
      check("pre_reset", {29'd0, bus.o_TX_Serial, bus.o_TX_Active, bus.o_TX_Done}, {29'd0, e});
    end
    exp_q.delete();
    #1 rst = 1'b1;
    #1;
    check("mid_rst_serial", 32'(bus.o_TX_Serial), 32'd1);
    check("mid_rst_active", 32'(bus.o_TX_Active), 32'd0);
    check("mid_rst_ready",  32'(bus.o_TX_Ready),  32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.o_TX_Done)    dc++;
      if (!bus.o_TX_Serial) lows++;
    end
    check("post_rst_no_done", 32'(dc), 32'd0);
    check("post_rst_line_idle", 32'(lows), 32'd0);
    frame(8'h5A, 1'b1, 4, 3, 0, 1'b0, "post_rst_frame");

    // Second push while the first frame is on the line.
    send(8'h11, 1'b1, 4, 3, 0, 1'b0);
    exp_q.delete();
    exp_q.push_back(3'b110);
    add_frame(8'h11, 3, 0, 1'b0, 4);
    if (HOLD_BUILD) begin
      mark = exp_q.size();
      add_frame(8'h22, 3, 0, 1'b0, 4);
      exp_q[mark] = exp_q[mark] | 3'b001;
      exp_q.push_back(3'b101);
      exp_q.push_back(3'b100);
    end else begin
      exp_q.push_back(3'b101);
      repeat (6) exp_q.push_back(3'b100);
    end
    fork
      run_samples("hold_push");
      begin
        repeat (8) @(negedge clk);
        apply_cfg(8'h22, 1'b1, 4, 3, 0, 1'b0);
        check("hold_ready_midframe", 32'(bus.o_TX_Ready), 32'(HOLD_BUILD));
        bus.i_TX_DV = 1'b1;
        @(posedge clk);
        #1;
        bus.i_TX_DV = 1'b0;
      end
    join
    check("hold_end_ready", 32'(bus.o_TX_Ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
